// File: rtl/branch_seq_if.sv
// Decoder-side bus of branch_seq: flag inputs, sequencing controls and PC/status outputs.
interface branch_seq_if #(
    parameter int PC_W = 8
);
    logic            z_flag;
    logic            z_next;
    logic            set_f;
    logic            inc;
    logic            stall;
    logic            jump_en;
    logic [1:0]      jump_cond;
    logic            link;
    logic [PC_W-1:0] jump_addr;
    logic [PC_W-1:0] pc;
    logic            taken;
    logic            flush;
    logic            lr_valid;

    modport master (
        output z_flag, z_next, set_f, inc, stall, jump_en, jump_cond, link, jump_addr,
        input  pc, taken, flush, lr_valid
    );

    modport slave (
        input  z_flag, z_next, set_f, inc, stall, jump_en, jump_cond, link, jump_addr,
        output pc, taken, flush, lr_valid
    );
endinterface

// File: rtl/branch_seq.sv
// Program-counter sequencer with conditional jumps, one-level link register and a post-redirect flush bubble.
// Optional macro BRANCH_SEQ_ZFWD_EN: jumps resolve on the zero flag being written in the same cycle.
//
// state | meaning
// RUN   | normal fetch: advance, jump or hold
// FLUSH | bubble after a taken jump; inc/jump_en ignored, pc held
module branch_seq #(
    parameter int          PC_W   = 8,
    parameter int unsigned RST_PC = 0
) (
    input logic          clk,
    input logic          rst,
    branch_seq_if.slave  bus
);
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, lr_q, lr_d, pc_inc;
    logic            lrv_q, lrv_d;
    logic            taken_q, taken_d;
    logic            flush_q, flush_d;
    logic            z_eff;
    logic            hit;

`ifdef BRANCH_SEQ_ZFWD_EN
    assign z_eff = bus.set_f ? bus.z_next : bus.z_flag;
`else
    assign z_eff = bus.z_flag;
    wire unused_zfwd = bus.set_f ^ bus.z_next;
`endif

    assign pc_inc = pc_q + 1'b1;

    always_comb begin
        hit = 1'b0;
        case (bus.jump_cond)
            2'b00:   hit = 1'b1;
            2'b01:   hit = z_eff;
            2'b10:   hit = ~z_eff;
            default: hit = lrv_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= RUN;
        else if (!bus.stall)
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.jump_en && hit) state_d = FLUSH;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        lr_d    = lr_q;
        lrv_d   = lrv_q;
        taken_d = 1'b0;
        flush_d = (state_d == FLUSH);
        if (state_q == RUN) begin
            if (bus.jump_en) begin
                if (hit) begin
                    taken_d = 1'b1;
                    if (bus.jump_cond == 2'b11) begin
                        pc_d  = lr_q;
                        lrv_d = 1'b0;
                    end else begin
                        pc_d = bus.jump_addr;
                        if (bus.link) begin
                            lr_d  = pc_inc;
                            lrv_d = 1'b1;
                        end
                    end
                end else begin
                    pc_d = pc_inc;
                end
            end else if (bus.inc) begin
                pc_d = pc_inc;
            end
        end
    end

    // Stall freezes everything except taken, which must not repeat its pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= PC_W'(RST_PC);
            lr_q    <= '0;
            lrv_q   <= 1'b0;
            taken_q <= 1'b0;
            flush_q <= 1'b0;
        end else if (bus.stall) begin
            taken_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            lr_q    <= lr_d;
            lrv_q   <= lrv_d;
            taken_q <= taken_d;
            flush_q <= flush_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.taken    = taken_q;
    assign bus.flush    = flush_q;
    assign bus.lr_valid = lrv_q;
endmodule

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq: directed scenarios then random stimulus against a cycle model.
module tb_branch_seq;
    localparam int PC_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    branch_seq_if #(.PC_W(PC_W)) bus ();

    branch_seq #(.PC_W(PC_W), .RST_PC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [7:0] m_pc, m_lr;
    bit         m_lrv, m_fl, m_tk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_lr = 8'h00; m_lrv = 0; m_fl = 0; m_tk = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},       32'(bus.pc),       32'(m_pc));
        chk({tag, ".taken"},    32'(bus.taken),    32'(m_tk));
        chk({tag, ".flush"},    32'(bus.flush),    32'(m_fl));
        chk({tag, ".lr_valid"}, 32'(bus.lr_valid), 32'(m_lrv));
    endtask

    // Called right after a falling edge: drive inputs, advance model, check after the next rise.
    task automatic step(input string tag, input bit st, input bit in, input bit je,
                        input logic [1:0] jc, input bit lk, input logic [7:0] ja,
                        input bit zf, input bit zn, input bit sf);
        bit z, go;
        bus.stall = st; bus.inc = in; bus.jump_en = je; bus.jump_cond = jc;
        bus.link = lk; bus.jump_addr = ja; bus.z_flag = zf; bus.z_next = zn; bus.set_f = sf;
`ifdef BRANCH_SEQ_ZFWD_EN
        z = sf ? zn : zf;
`else
        z = zf;
`endif
        if (st) begin
            m_tk = 0;
        end else if (m_fl) begin
            m_fl = 0;
            m_tk = 0;
        end else if (je) begin
            go = (jc == 2'd0) || (jc == 2'd1 && z) || (jc == 2'd2 && !z) || (jc == 2'd3 && m_lrv);
            if (go) begin
                if (jc == 2'd3) begin
                    m_pc  = m_lr;
                    m_lrv = 0;
                end else begin
                    if (lk) begin
                        m_lr  = m_pc + 8'd1;
                        m_lrv = 1;
                    end
                    m_pc = ja;
                end
            end else begin
                m_pc = m_pc + 8'd1;
            end
            m_fl = go;
            m_tk = go;
        end else begin
            if (in) m_pc = m_pc + 8'd1;
            m_tk = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 2'd0, 0, 8'h00, 0, 0, 0);
    endtask

    task automatic incr(input string tag);
        step(tag, 0, 1, 0, 2'd0, 0, 8'h00, 0, 0, 0);
    endtask

    task automatic jmp(input string tag, input logic [1:0] jc, input bit lk, input logic [7:0] ja, input bit zf);
        step(tag, 0, 0, 1, jc, lk, ja, zf, 0, 0);
    endtask

    initial begin
        bus.stall = 0; bus.inc = 0; bus.jump_en = 0; bus.jump_cond = 2'd0;
        bus.link = 0; bus.jump_addr = '0; bus.z_flag = 0; bus.z_next = 0; bus.set_f = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all("reset");

        repeat (5) incr("cnt");
        chk("cnt5", 32'(bus.pc), 32'h05);

        // Asynchronous reset must take effect between clock edges.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.pc", 32'(bus.pc), 32'h00);
        chk("arst.taken", 32'(bus.taken), 32'h0);
        chk("arst.flush", 32'(bus.flush), 32'h0);
        chk("arst.lrv", 32'(bus.lr_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        jmp("j_ff", 2'd0, 0, 8'hFF, 0);
        idle("fl_ff");
        incr("wrap");
        chk("wrap0", 32'(bus.pc), 32'h00);

        jmp("j_10", 2'd0, 0, 8'h10, 0);
        idle("fl_10");
        repeat (3) incr("inc3");
        chk("inc3_13", 32'(bus.pc), 32'h13);

        jmp("jz1", 2'd1, 0, 8'h40, 1);
        chk("jz1.pc", 32'(bus.pc), 32'h40);
        chk("jz1.tf", 32'({bus.taken, bus.flush}), 32'h3);
        incr("jz1.hold");
        chk("jz1.held", 32'(bus.pc), 32'h40);
        incr("jz1.res");
        chk("jz1.41", 32'(bus.pc), 32'h41);
        jmp("jz0", 2'd1, 0, 8'h40, 0);
        chk("jz0.pc", 32'(bus.pc), 32'h42);
        chk("jz0.tf", 32'({bus.taken, bus.flush}), 32'h0);

        jmp("j_20", 2'd0, 0, 8'h20, 0);
        idle("fl_20");
        jmp("call", 2'd0, 1, 8'h80, 0);
        chk("call.pc", 32'(bus.pc), 32'h80);
        chk("call.lrv", 32'(bus.lr_valid), 32'h1);
        idle("fl_call");
        jmp("ret", 2'd3, 1, 8'h55, 0);
        chk("ret.pc", 32'(bus.pc), 32'h21);
        chk("ret.lrv", 32'(bus.lr_valid), 32'h0);
        idle("fl_ret");
        jmp("ret2", 2'd3, 0, 8'h55, 0);
        chk("ret2.pc", 32'(bus.pc), 32'h22);
        chk("ret2.taken", 32'(bus.taken), 32'h0);

        step("zfwd", 0, 0, 1, 2'd1, 0, 8'h30, 0, 1, 1);
`ifdef BRANCH_SEQ_ZFWD_EN
        chk("zfwd.pc", 32'(bus.pc), 32'h30);
        chk("zfwd.taken", 32'(bus.taken), 32'h1);
        idle("fl_zfwd");
`else
        chk("zfwd.pc", 32'(bus.pc), 32'h23);
        chk("zfwd.taken", 32'(bus.taken), 32'h0);
`endif

        jmp("j_50", 2'd0, 0, 8'h50, 0);
        repeat (3) begin
            step("stall", 1, 1, 1, 2'd0, 0, 8'h99, 0, 0, 0);
            chk("stall.pc", 32'(bus.pc), 32'h50);
            chk("stall.tf", 32'({bus.taken, bus.flush}), 32'h1);
        end
        incr("unstall");
        chk("unstall.pc", 32'(bus.pc), 32'h50);
        chk("unstall.flush", 32'(bus.flush), 32'h0);
        incr("unstall.run");
        chk("unstall.51", 32'(bus.pc), 32'h51);

        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(7) == 0), 1'($urandom), ($urandom_range(2) == 0),
                 2'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
